// File: rtl/data_c_width_combin_if.sv
// rtl/data_c_width_combin_if.sv - stream and flush signals for the width combiner
//
// Bundles the narrow input beat stream, the flush request and the wide output
// word stream of data_c_width_combin.
//   in_valid / in_data / in_ready       narrow beat handshake (ISIZE bits)
//   flush                               level request to emit a partial word
//   out_valid / out_data / out_cnt      packed word (ISIZE*NUM bits) and beat count
//   out_ready                           downstream accept
// Modports:
//   master - the upstream producer / downstream consumer side (drives beats, out_ready)
//   slave  - the combiner itself
interface data_c_width_combin_if #(
    parameter int ISIZE = 8,
    parameter int NUM   = 4
);
    localparam int OSIZE = ISIZE * NUM;
    localparam int CW    = $clog2(NUM + 1);

    logic             in_valid;
    logic [ISIZE-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic [OSIZE-1:0] out_data;
    logic [CW-1:0]    out_cnt;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        output flush,
        input  out_valid,
        input  out_data,
        input  out_cnt,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        input  flush,
        output out_valid,
        output out_data,
        output out_cnt,
        input  out_ready
    );
endinterface

// File: rtl/data_c_width_combin.sv
// rtl/data_c_width_combin.sv - packs NUM narrow stream beats into one wide word
//
// Accumulates NUM consecutive ISIZE-bit beats, first beat in the MSB lane, and
// presents the (ISIZE*NUM)-bit word on a registered output stage. A flush
// request emits whatever has been gathered so far with the unused lanes zeroed.
// One beat per cycle is accepted whenever the output stage is empty or draining.
// Ports:
//   clock  - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of data_c_width_combin_if (beats in, words out, flush)
module data_c_width_combin #(
    parameter int ISIZE = 8,
    parameter int NUM   = 4
) (
    input  logic                   clock,
    input  logic                   rst_n,
    data_c_width_combin_if.slave   bus
);
    localparam int OSIZE = ISIZE * NUM;
    localparam int CW    = $clog2(NUM + 1);

    logic [OSIZE-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             out_valid_q;
    logic [OSIZE-1:0] out_data_q;
    logic [CW-1:0]    out_cnt_q;

    logic             in_ready;
    logic             acc_en;
    logic             flush_en;
    logic [CW-1:0]    n_eff;
    logic             complete;
    logic             emit;
    logic [OSIZE-1:0] acc_ins;

    // The output register may take a new word only if it is empty or being
    // drained this very cycle; this is the only comb path (out_ready -> in_ready).
    assign in_ready = !out_valid_q || bus.out_ready;
    assign acc_en   = bus.in_valid && in_ready;
    assign flush_en = bus.flush && in_ready;

    // Beats held plus the one arriving now; cnt never exceeds NUM-1, so this
    // fits in CW bits.
    assign n_eff    = cnt + CW'(acc_en);
    assign complete = acc_en && (cnt == CW'(NUM - 1));
    assign emit     = complete || (flush_en && (n_eff != '0));

    // Accumulator with the current beat dropped into lane cnt (lane 0 = MSBs).
    // Lanes past cnt are always zero because acc is cleared on every emit, which
    // gives the zero padding of a flushed partial word for free.
    always_comb begin
        acc_ins = acc;
        for (int i = 0; i < NUM; i++) begin
            if (acc_en && (cnt == CW'(i))) begin
                acc_ins[(NUM-1-i)*ISIZE +: ISIZE] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
        end else begin
            if (emit) begin
                // Replaces any word draining this cycle: back-to-back, no bubble.
                out_valid_q <= 1'b1;
                out_data_q  <= acc_ins;
                out_cnt_q   <= n_eff;
                acc         <= '0;
                cnt         <= '0;
            end else begin
                if (acc_en) begin
                    acc <= acc_ins;
                    cnt <= cnt + CW'(1);
                end
                if (out_valid_q && bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_cnt_q   <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_cnt   = out_cnt_q;

`ifndef SYNTHESIS
    // Stall must freeze the output word.
    property p_stall_hold;
        @(posedge clock) disable iff (!rst_n)
            (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_cnt_q));
    endproperty
    a_stall_hold: assert property (p_stall_hold);

    // Beat counter stays below NUM.
    property p_cnt_range;
        @(posedge clock) disable iff (!rst_n) cnt < CW'(NUM);
    endproperty
    a_cnt_range: assert property (p_cnt_range);
`endif
endmodule

// File: tb/tb_data_c_width_combin.sv
// tb/tb_data_c_width_combin.sv - self-checking bench for data_c_width_combin
module tb_data_c_width_combin;
    localparam int ISIZE = 8;
    localparam int NUM   = 4;
    localparam int OSIZE = ISIZE * NUM;

    logic clock;
    logic rst_n;
    int   checks;
    int   errors;

    data_c_width_combin_if #(.ISIZE(ISIZE), .NUM(NUM)) dif ();

    data_c_width_combin #(.ISIZE(ISIZE), .NUM(NUM)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a queue of pending beats and the expected output register.
    logic [ISIZE-1:0] beats[$];
    logic             m_ov;
    logic [63:0]      m_od;
    int               m_oc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        beats.delete();
        m_ov = 1'b0;
        m_od = '0;
        m_oc = 0;
    endtask

    // Called at the rising edge with the inputs that the DUT sampled there.
    task automatic model_edge(input logic iv, input logic [ISIZE-1:0] id, input logic fl, input logic ordy);
        logic rdy;
        rdy = !m_ov || ordy;
        if (iv && rdy) beats.push_back(id);
        if (beats.size() == NUM || (fl && rdy && beats.size() > 0)) begin
            m_od = '0;
            foreach (beats[i]) m_od = m_od | (64'(beats[i]) << (OSIZE - (i + 1) * ISIZE));
            m_oc = beats.size();
            m_ov = 1'b1;
            beats.delete();
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
            m_od = '0;
            m_oc = 0;
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic step(input logic iv, input logic [ISIZE-1:0] id, input logic fl, input logic ordy);
        dif.in_valid  = iv;
        dif.in_data   = id;
        dif.flush     = fl;
        dif.out_ready = ordy;
        #1;
        check("in_ready",  64'(dif.in_ready),  64'(!m_ov || ordy));
        check("out_valid", 64'(dif.out_valid), 64'(m_ov));
        check("out_data",  64'(dif.out_data),  m_od);
        check("out_cnt",   64'(dif.out_cnt),   64'(m_oc));
        @(posedge clock);
        model_edge(iv, id, fl, ordy);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_data   = '0;
        dif.flush     = 1'b0;
        dif.out_ready = 1'b1;
        #1;
        model_clear();
        check("rst_valid", 64'(dif.out_valid), 64'd0);
        check("rst_data",  64'(dif.out_data),  64'd0);
        check("rst_cnt",   64'(dif.out_cnt),   64'd0);
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [ISIZE-1:0] b1;
        logic [ISIZE-1:0] b4;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        @(negedge clock);
        do_reset();

        // Four beats, one word one cycle after the last beat.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b1);
        check("t1_valid", 64'(dif.out_valid), 64'd1);
        check("t1_data",  64'(dif.out_data),  64'h11223344);
        check("t1_cnt",   64'(dif.out_cnt),   64'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_gone",  64'(dif.out_valid), 64'd0);

        // Eight beats continuous.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i * 8'h11), 1'b0, 1'b1);
            if (i == 4) check("t2_w0", 64'(dif.out_data), 64'h11223344);
            if (i == 8) check("t2_w1", 64'(dif.out_data), 64'h55667788);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush a partial word without a beat, then flush with nothing held.
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("t3_data", 64'(dif.out_data), 64'hAABB0000);
        check("t3_cnt",  64'(dif.out_cnt),  64'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("t3_empty_flush", 64'(dif.out_valid), 64'd0);

        // Beat accepted in the flush cycle joins the word.
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        step(1'b1, 8'hCC, 1'b1, 1'b1);
        check("t4_data", 64'(dif.out_data), 64'hAABBCC00);
        check("t4_cnt",  64'(dif.out_cnt),  64'd3);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Stall for five cycles with beats and flush offered.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hEE, 1'b1, 1'b0);
            check("t5_hold", 64'(dif.out_data), 64'h11121314);
        end
        dif.out_ready = 1'b1;
        #1;
        check("t5_ready_comb", 64'(dif.in_ready), 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a word.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b0, 1'b1);
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_quiet", 64'(dif.out_valid), 64'd0);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        check("t6_data", 64'(dif.out_data), 64'h01020304);
        check("t6_cnt",  64'(dif.out_cnt),  64'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            b1 = 8'($urandom);
            b4 = 8'($urandom_range(0, 15));
            step(($urandom_range(0, 3) != 0), b1, (b4 == 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
